// File: rtl/core_host_ctrl_if.sv
// Host <-> core signal bundle: program load stream, instruction fetch port and retire status stream.
interface core_host_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              i_ld_valid;
  logic [INST_W-1:0] i_ld_data;
  logic              i_ld_last;
  logic              o_ld_ready;
  logic [ADDR_W-1:0] i_i_addr;
  logic [INST_W-1:0] o_i_inst;
  logic [1:0]        i_status;
  logic              i_status_valid;

  modport master (
    output i_ld_valid, i_ld_data, i_ld_last, i_i_addr, i_status, i_status_valid,
    input  o_ld_ready, o_i_inst
  );

  modport slave (
    input  i_ld_valid, i_ld_data, i_ld_last, i_i_addr, i_status, i_status_valid,
    output o_ld_ready, o_i_inst
  );
endinterface

// File: rtl/core_host_ctrl.sv
// Host controller for the instruction-set core: loads instruction memory, runs the core out of reset,
// serves fetches and tallies retired instructions until a terminal status or the watchdog ends the run.
module core_host_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int DEPTH   = 256,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  core_host_ctrl_if.slave  bus,
  output logic             o_core_rst_n,
  output logic             o_done,
  output logic [1:0]       o_final_status,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_r_cnt,
  output logic [CNT_W-1:0] o_i_cnt
);
  // state | meaning: IDLE wait start | LOAD fill memory | RUN core released | DONE result held
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LD_W  = IDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [INST_W-1:0] EOF_WORD = INST_W'(32'hFC00_0000);
  localparam logic [TMR_W-1:0]  TMR_INIT = TMR_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        final_q, final_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic [INST_W-1:0] mem_q [DEPTH];

  logic              ld_ready;
  logic              ld_xfer;
  logic              term;
  logic [IDX_W-1:0]  fetch_idx;
  logic [ADDR_W+1:0] fetch_lim;
  logic [ADDR_W+1:0] fetch_addr;
  logic              fetch_hit;

  assign ld_ready = (state_q == S_LOAD) && (ld_cnt_q < LD_W'(DEPTH));
  assign ld_xfer  = bus.i_ld_valid && ld_ready;
  assign term     = bus.i_status_valid && bus.i_status[1];

  // Word-aligned fetches inside the loaded region hit; everything else returns EOF to stop the core.
  always_comb begin
    fetch_idx  = bus.i_i_addr[IDX_W+1:2];
    fetch_lim  = {{(ADDR_W-IDX_W-1){1'b0}}, ld_cnt_q, 2'b00};
    fetch_addr = {2'b00, bus.i_i_addr};
    fetch_hit  = (bus.i_i_addr[1:0] == 2'b00) && (fetch_addr < fetch_lim);
    bus.o_i_inst = fetch_hit ? mem_q[fetch_idx] : EOF_WORD;
  end

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    r_cnt_d      = r_cnt_q;
    i_cnt_d      = i_cnt_q;
    tmr_d        = tmr_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    final_d      = final_q;
    core_rst_n_d = core_rst_n_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_LOAD;
          ld_cnt_d  = '0;
          r_cnt_d   = '0;
          i_cnt_d   = '0;
          tmr_d     = TMR_INIT;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          final_d   = 2'd0;
        end
      end
      S_LOAD: begin
        if (ld_xfer) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (bus.i_ld_last || (ld_cnt_q == LD_W'(DEPTH - 1))) begin
            state_d      = S_RUN;
            core_rst_n_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Watchdog counts down to zero; the cycle where it reads zero is the last allowed run cycle.
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        if (bus.i_status_valid && (bus.i_status == 2'd0) && (r_cnt_q != '1)) r_cnt_d = r_cnt_q + 1'b1;
        if (bus.i_status_valid && (bus.i_status == 2'd1) && (i_cnt_q != '1)) i_cnt_d = i_cnt_q + 1'b1;
        if (term) begin
          final_d      = bus.i_status;
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_rst_n_d = 1'b0;
        end else if (tmr_q == '0) begin
          final_d      = 2'd0;
          timeout_d    = 1'b1;
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_rst_n_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ld_cnt_q     <= '0;
      r_cnt_q      <= '0;
      i_cnt_q      <= '0;
      tmr_q        <= TMR_INIT;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      final_q      <= 2'd0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      r_cnt_q      <= r_cnt_d;
      i_cnt_q      <= i_cnt_d;
      tmr_q        <= tmr_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      final_q      <= final_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ld_xfer) mem_q[ld_cnt_q[IDX_W-1:0]] <= bus.i_ld_data;
  end

  assign bus.o_ld_ready = ld_ready;
  assign o_core_rst_n   = core_rst_n_q;
  assign o_done         = done_q;
  assign o_final_status = final_q;
  assign o_timeout      = timeout_q;
  assign o_r_cnt        = r_cnt_q;
  assign o_i_cnt        = i_cnt_q;
endmodule

// File: tb/tb_core_host_ctrl.sv
// Directed bench for core_host_ctrl: small DEPTH/TIMEOUT/CNT_W so bounds and saturation are reachable.
module tb_core_host_ctrl;
  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam logic [31:0] EOFW = 32'hFC00_0000;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0;
  logic o_core_rst_n, o_done, o_timeout;
  logic [1:0] o_final_status;
  logic [CNT_W-1:0] o_r_cnt, o_i_cnt;

  core_host_ctrl_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  core_host_ctrl #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .bus(bus.slave),
    .o_core_rst_n(o_core_rst_n),
    .o_done(o_done),
    .o_final_status(o_final_status),
    .o_timeout(o_timeout),
    .o_r_cnt(o_r_cnt),
    .o_i_cnt(o_i_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Reference model: phase, words loaded, run cycles elapsed, plain saturating tallies.
  int m_ph = PH_IDLE;
  int m_words = 0;
  int m_cyc = 0;
  int m_r = 0;
  int m_i = 0;
  int m_fs = 0;
  bit m_done = 1'b0;
  bit m_to = 1'b0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] ld_buf [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    longint lim;
    lim = 4 * longint'(m_words);
    if (a[1:0] == 2'b00 && longint'(a) < lim) return m_mem[int'(a >> 2)];
    return EOFW;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_ph <= PH_IDLE; m_words <= 0; m_cyc <= 0; m_r <= 0; m_i <= 0;
      m_fs <= 0; m_done <= 1'b0; m_to <= 1'b0;
    end else begin
      case (m_ph)
        PH_IDLE, PH_DONE: if (i_start) begin
          m_ph <= PH_LOAD; m_words <= 0; m_cyc <= 0; m_r <= 0; m_i <= 0;
          m_fs <= 0; m_done <= 1'b0; m_to <= 1'b0;
        end
        PH_LOAD: if (bus.i_ld_valid && m_words < DEPTH) begin
          m_mem[m_words] <= bus.i_ld_data;
          m_words <= m_words + 1;
          if (bus.i_ld_last || m_words + 1 == DEPTH) m_ph <= PH_RUN;
        end
        PH_RUN: begin
          m_cyc <= m_cyc + 1;
          if (bus.i_status_valid && bus.i_status == 2'd0 && m_r < CMAX) m_r <= m_r + 1;
          if (bus.i_status_valid && bus.i_status == 2'd1 && m_i < CMAX) m_i <= m_i + 1;
          if (bus.i_status_valid && bus.i_status >= 2'd2) begin
            m_fs <= int'(bus.i_status); m_ph <= PH_DONE; m_done <= 1'b1;
          end else if (m_cyc == TIMEOUT - 1) begin
            m_fs <= 0; m_to <= 1'b1; m_ph <= PH_DONE; m_done <= 1'b1;
          end
        end
        default: m_ph <= PH_IDLE;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("core_rst_n", o_core_rst_n, m_ph == PH_RUN);
      chk("ld_ready", bus.o_ld_ready, m_ph == PH_LOAD && m_words < DEPTH);
      chk("done", o_done, m_done);
      chk("timeout", o_timeout, m_to);
      chk("final_status", o_final_status, m_fs);
      chk("r_cnt", o_r_cnt, m_r);
      chk("i_cnt", o_i_cnt, m_i);
      chk("i_inst", bus.o_i_inst, exp_inst(bus.i_i_addr));
    end
  end

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic do_start();
    i_start = 1'b1; cyc(); i_start = 1'b0;
  endtask

  task automatic send_status(input logic [1:0] s);
    bus.i_status = s; bus.i_status_valid = 1'b1; cyc(); bus.i_status_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit use_last, output int acc);
    acc = 0;
    for (int k = 0; k < n; k++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = ld_buf[k];
      bus.i_ld_last  = use_last && (k == n - 1);
      @(negedge i_clk);
      if (bus.o_ld_ready) acc++;
      cyc();
    end
    bus.i_ld_valid = 1'b0;
    bus.i_ld_last  = 1'b0;
  endtask

  task automatic fetch_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    bus.i_i_addr = a;
    @(negedge i_clk);
    chk(nm, bus.o_i_inst, e);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int acc;
    int nrun;
    bus.i_ld_valid = 1'b0; bus.i_ld_data = '0; bus.i_ld_last = 1'b0;
    bus.i_i_addr = '0; bus.i_status = 2'd0; bus.i_status_valid = 1'b0;
    repeat (2) cyc();
    cmp_en = 1'b1;
    @(negedge i_clk);
    chk("rst_core_rst_n", o_core_rst_n, 1'b0);
    chk("rst_ld_ready", bus.o_ld_ready, 1'b0);
    chk("rst_done", o_done, 1'b0);
    cyc();
    i_rst_n = 1'b1;
    cyc();

    // Three-word program, core stub fetches and retires add, addi, EOF.
    ld_buf[0] = 32'h0400_0000; ld_buf[1] = 32'h1400_0005; ld_buf[2] = 32'hFC00_0000;
    do_start();
    load(3, 1'b1, acc);
    chk("s1_ready_cycles", acc, 3);
    @(negedge i_clk);
    chk("s1_core_released", o_core_rst_n, 1'b1);
    cyc();
    fetch_chk("fetch_0", 32'd0, 32'h0400_0000);
    fetch_chk("fetch_4", 32'd4, 32'h1400_0005);
    fetch_chk("fetch_8", 32'd8, 32'hFC00_0000);
    fetch_chk("fetch_12_unloaded", 32'd12, EOFW);
    fetch_chk("fetch_2_misaligned", 32'd2, EOFW);
    fetch_chk("fetch_high_no_wrap", 32'h8000_0000, EOFW);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    send_status(2'd0); send_status(2'd1); send_status(2'd3);
    send_status(2'd0);
    @(negedge i_clk);
    chk("s1_r_cnt", o_r_cnt, 1);
    chk("s1_i_cnt", o_i_cnt, 1);
    chk("s1_final", o_final_status, 2'd3);
    chk("s1_done", o_done, 1'b1);
    chk("s1_core_held", o_core_rst_n, 1'b0);
    cyc();

    // Overflow termination after two R-type retires.
    do_start();
    load(3, 1'b1, acc);
    send_status(2'd0); send_status(2'd0); send_status(2'd2);
    @(negedge i_clk);
    chk("s2_r_cnt", o_r_cnt, 2);
    chk("s2_i_cnt", o_i_cnt, 0);
    chk("s2_final", o_final_status, 2'd2);
    chk("s2_timeout", o_timeout, 1'b0);
    cyc();

    // Watchdog with no terminal status: exactly TIMEOUT run cycles.
    do_start();
    load(1, 1'b1, acc);
    nrun = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_core_rst_n) nrun++;
      else break;
    end
    chk("wd_run_cycles", nrun, 16);
    chk("wd_timeout", o_timeout, 1'b1);
    chk("wd_final", o_final_status, 2'd0);
    chk("wd_done", o_done, 1'b1);
    cyc();

    // Terminal status in the watchdog cycle beats the timeout.
    do_start();
    load(1, 1'b1, acc);
    repeat (15) cyc();
    send_status(2'd3);
    @(negedge i_clk);
    chk("wd_tie_timeout", o_timeout, 1'b0);
    chk("wd_tie_final", o_final_status, 2'd3);
    chk("wd_tie_done", o_done, 1'b1);
    cyc();

    // Retire counters saturate at all-ones.
    do_start();
    load(1, 1'b1, acc);
    repeat (10) send_status(2'd0);
    repeat (2) send_status(2'd1);
    send_status(2'd2);
    @(negedge i_clk);
    chk("sat_r_cnt", o_r_cnt, 7);
    chk("sat_i_cnt", o_i_cnt, 2);
    cyc();

    // Stream longer than memory, never last: only DEPTH words taken.
    for (int k = 0; k < 6; k++) ld_buf[k] = 32'hA000_0000 + 32'(k);
    do_start();
    load(6, 1'b0, acc);
    chk("full_accepted", acc, 4);
    @(negedge i_clk);
    chk("full_ready_low", bus.o_ld_ready, 1'b0);
    chk("full_running", o_core_rst_n, 1'b1);
    cyc();
    fetch_chk("full_fetch_12", 32'd12, 32'hA000_0003);
    fetch_chk("full_fetch_16", 32'd16, EOFW);
    send_status(2'd3);

    // Asynchronous reset in the middle of a run, then a clean reload.
    ld_buf[0] = 32'hB000_0000; ld_buf[1] = 32'hB000_0001; ld_buf[2] = 32'hB000_0002;
    do_start();
    load(2, 1'b1, acc);
    send_status(2'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_core_rst_n", o_core_rst_n, 1'b0);
    chk("arst_r_cnt", o_r_cnt, 0);
    chk("arst_ld_ready", bus.o_ld_ready, 1'b0);
    cyc();
    i_rst_n = 1'b1;
    cyc();
    do_start();
    load(3, 1'b1, acc);
    @(negedge i_clk);
    chk("reload_done_clear", o_done, 1'b0);
    cyc();
    fetch_chk("reload_fetch_8", 32'd8, 32'hB000_0002);
    send_status(2'd3);
    @(negedge i_clk);
    chk("reload_final", o_final_status, 2'd3);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
